// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern scheduler.
//   sched_state_t  : scheduler FSM state encoding
//   MODE_*         : one-hot mode codes driven to the pattern engine
//   idx_to_onehot  : mode index (0..3) -> one-hot mode code
//   onehot_to_idx  : one-hot mode code -> mode index
//   is_onehot      : true when exactly one of the four mode bits is set
package led_pkg;

  localparam int MODE_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MANUAL   = 2'd1,
    AUTO_RUN = 2'd2,
    CLEAR    = 2'd3
  } sched_state_t;

  localparam logic [MODE_W-1:0] MODE_CLEAR  = 4'b0000;
  localparam logic [MODE_W-1:0] MODE_BLINK2 = 4'b0001;
  localparam logic [MODE_W-1:0] MODE_TOGGLE = 4'b0010;
  localparam logic [MODE_W-1:0] MODE_ALT    = 4'b0100;
  localparam logic [MODE_W-1:0] MODE_SHIFT  = 4'b1000;

  function automatic logic [MODE_W-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [MODE_W-1:0] oh;
    oh = MODE_CLEAR;
    case (idx)
      2'd0: oh = MODE_BLINK2;
      2'd1: oh = MODE_TOGGLE;
      2'd2: oh = MODE_ALT;
      2'd3: oh = MODE_SHIFT;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [MODE_W-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      MODE_TOGGLE: idx = 2'd1;
      MODE_ALT:    idx = 2'd2;
      MODE_SHIFT:  idx = 2'd3;
      default:     idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MODE_W-1:0] v);
    logic hit;
    hit = 1'b0;
    case (v)
      MODE_BLINK2, MODE_TOGGLE, MODE_ALT, MODE_SHIFT: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/led_pattern_scheduler_sw_debounce.sv
// Switch conditioning for the LED pattern scheduler.
//   clk, rst_n : clock and asynchronous active-low reset
//   raw        : raw switch bank, asynchronous to clk
//   sw_db      : debounced switch value
// Two-flop synchroniser followed by a stability counter. The counter restarts
// on every change of the synchronised value; sw_db takes the new value CYC
// clocks after the last change (2 + CYC clocks after the raw edge).
module sw_debounce
  import led_pkg::*;
#(
  parameter int W   = MODE_W,
  parameter int CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] sw_db
);

  localparam int CW = $clog2(CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYC);
  localparam logic [CW-1:0] CNT_HIT = CW'(CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  sync2_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
      cnt     <= '0;
      sw_db   <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      sync2_d <= sync2;
      // The change is seen one clock after sync2 moves, so the restart value
      // is 1: that clock already counts toward the stable window.
      if (sync2 != sync2_d) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if ((sync2 == sync2_d) && (cnt == CNT_HIT)) begin
        sw_db <= sync2;
      end
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// LED pattern engine scheduler.
//   i_clk       : clock
//   i_rst_n     : asynchronous active-low reset
//   i_sw        : raw one-hot mode switches (asynchronous)
//   i_auto_en   : enable automatic rotation while switches are all zero
//   i_pat_done  : one-cycle pulse, engine finished one pattern pass
//   o_mode      : one-hot mode to the engine, 0000 = clear / re-arm
//   o_mode_idx  : index of the current or last mode
//   o_tick      : one-cycle engine step enable
//   o_auto      : high while running, or clearing toward, an automatic mode
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no mode selected, o_mode = 0000
// MANUAL   | switch-selected mode driven, prescaler running
// AUTO_RUN | rotating mode driven, counting pattern passes and ticks
// CLEAR    | 0000 gap before the next mode so the engine re-arms
module led_pattern_scheduler
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TICK_DIV     = 4,
  parameter int CLEAR_CYC    = 2,
  parameter int REPEATS      = 2,
  parameter int DWELL_TICKS  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [MODE_W-1:0] i_sw,
  input  logic              i_auto_en,
  input  logic              i_pat_done,
  output logic [MODE_W-1:0] o_mode,
  output logic [1:0]        o_mode_idx,
  output logic              o_tick,
  output logic              o_auto
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(CLEAR_CYC + 1);
  localparam int DW = $clog2(REPEATS + 1);
  localparam int TW = $clog2(DWELL_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);
  localparam logic [GW-1:0] GAP_LAST   = GW'(CLEAR_CYC - 1);
  localparam logic [DW-1:0] DONE_MAX   = DW'(REPEATS);
  localparam logic [TW-1:0] TICK_MAX   = TW'(DWELL_TICKS);

  sched_state_t      state;
  logic [MODE_W-1:0] sw_db;
  logic [MODE_W-1:0] sw_prev;
  logic [PW-1:0]     presc;
  logic [GW-1:0]     gap_cnt;
  logic [DW-1:0]     done_cnt;
  logic [TW-1:0]     tick_cnt;
  logic              tgt_auto;

  logic              sw_oh;
  logic [1:0]        sw_idx;
  logic [DW-1:0]     done_nxt;
  logic [TW-1:0]     tick_nxt;
  logic              advance;

  sw_debounce #(
    .W   (MODE_W),
    .CYC (DEBOUNCE_CYC)
  ) u_sw_debounce (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .raw   (i_sw),
    .sw_db (sw_db)
  );

  // Advance is decided on the counters' next values so a limit reached this
  // cycle moves on immediately; a pass and a dwell tick landing together
  // still yield a single advance because it is one OR.
  always_comb begin
    sw_oh    = is_onehot(sw_db);
    sw_idx   = onehot_to_idx(sw_db);
    done_nxt = done_cnt;
    tick_nxt = tick_cnt;
    if (i_pat_done && (done_cnt != DONE_MAX)) begin
      done_nxt = done_cnt + 1'b1;
    end
    if (o_tick && (tick_cnt != TICK_MAX)) begin
      tick_nxt = tick_cnt + 1'b1;
    end
    advance = (done_nxt == DONE_MAX) || (tick_nxt == TICK_MAX);
  end

  // Counters and the prescaler default to zero and only hold/advance in the
  // branch that stays in their state, so every CLEAR entry starts them clean.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_mode     <= MODE_CLEAR;
      o_mode_idx <= 2'd0;
      o_tick     <= 1'b0;
      o_auto     <= 1'b0;
      presc      <= '0;
      gap_cnt    <= '0;
      done_cnt   <= '0;
      tick_cnt   <= '0;
      tgt_auto   <= 1'b0;
      sw_prev    <= '0;
    end else begin
      sw_prev  <= sw_db;
      o_tick   <= 1'b0;
      presc    <= '0;
      gap_cnt  <= '0;
      done_cnt <= '0;
      tick_cnt <= '0;

      case (state)
        IDLE: begin
          if (sw_oh) begin
            state      <= CLEAR;
            o_mode     <= MODE_CLEAR;
            o_mode_idx <= sw_idx;
            tgt_auto   <= 1'b0;
            o_auto     <= 1'b0;
          end else if ((sw_db == MODE_CLEAR) && i_auto_en) begin
            state    <= CLEAR;
            o_mode   <= MODE_CLEAR;
            tgt_auto <= 1'b1;
            o_auto   <= 1'b1;
          end
        end

        MANUAL: begin
          if (sw_oh && (sw_db != o_mode)) begin
            state      <= CLEAR;
            o_mode     <= MODE_CLEAR;
            o_mode_idx <= sw_idx;
            tgt_auto   <= 1'b0;
            o_auto     <= 1'b0;
          end else if (!sw_oh) begin
            state  <= IDLE;
            o_mode <= MODE_CLEAR;
            o_auto <= 1'b0;
          end else begin
            presc  <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            o_tick <= (presc == PRESC_PRE);
          end
        end

        AUTO_RUN: begin
          if (sw_oh) begin
            state      <= CLEAR;
            o_mode     <= MODE_CLEAR;
            o_mode_idx <= sw_idx;
            tgt_auto   <= 1'b0;
            o_auto     <= 1'b0;
          end else if (!i_auto_en || (sw_db != MODE_CLEAR)) begin
            state  <= IDLE;
            o_mode <= MODE_CLEAR;
            o_auto <= 1'b0;
          end else if (advance) begin
            state      <= CLEAR;
            o_mode     <= MODE_CLEAR;
            o_mode_idx <= o_mode_idx + 2'd1;
            tgt_auto   <= 1'b1;
            o_auto     <= 1'b1;
          end else begin
            presc    <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            o_tick   <= (presc == PRESC_PRE);
            done_cnt <= done_nxt;
            tick_cnt <= tick_nxt;
          end
        end

        CLEAR: begin
          if (sw_db != sw_prev) begin
            // Re-target; gap_cnt already defaults back to zero.
            if (sw_oh) begin
              o_mode_idx <= sw_idx;
              tgt_auto   <= 1'b0;
              o_auto     <= 1'b0;
            end else if ((sw_db == MODE_CLEAR) && i_auto_en) begin
              tgt_auto <= 1'b1;
              o_auto   <= 1'b1;
            end else begin
              state  <= IDLE;
              o_auto <= 1'b0;
            end
          end else if (gap_cnt == GAP_LAST) begin
            if (!tgt_auto) begin
              state  <= MANUAL;
              o_mode <= idx_to_onehot(o_mode_idx);
            end else if (i_auto_en) begin
              state  <= AUTO_RUN;
              o_mode <= idx_to_onehot(o_mode_idx);
              o_auto <= 1'b1;
            end else begin
              state  <= IDLE;
              o_auto <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          o_mode <= MODE_CLEAR;
          o_auto <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
module tb_led_pattern_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       auto_en;
  logic       pat_done;
  logic [3:0] mode;
  logic [1:0] mode_idx;
  logic       tick;
  logic       auto;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  led_pattern_scheduler dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sw       (sw),
    .i_auto_en  (auto_en),
    .i_pat_done (pat_done),
    .o_mode     (mode),
    .o_mode_idx (mode_idx),
    .o_tick     (tick),
    .o_auto     (auto)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ei;
    rst_n = 1'b0; sw = 4'b0000; auto_en = 1'b0; pat_done = 1'b0;
    repeat (3) step();
    chk("rst_mode", mode, 4'b0000);
    chk("rst_idx", {2'b00, mode_idx}, 4'd0);
    chk("rst_tick", {3'b000, tick}, 4'd0);
    chk("rst_auto", {3'b000, auto}, 4'd0);

    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_no_auto", mode, 4'b0000);

    // Manual select: 2 sync + 4 debounce + 1 FSM + 2 clear = 9 clocks.
    sw = 4'b0010;
    repeat (8) step();
    chk("man_gap", mode, 4'b0000);
    step();
    chk("man_mode", mode, 4'b0010);
    chk("man_idx", {2'b00, mode_idx}, 4'd1);
    chk("man_auto", {3'b000, auto}, 4'd0);
    repeat (2) step();
    chk("man_tick_lo", {3'b000, tick}, 4'd0);
    step();
    chk("man_tick_1", {3'b000, tick}, 4'd1);
    step();
    chk("man_tick_lo2", {3'b000, tick}, 4'd0);
    repeat (3) step();
    chk("man_tick_2", {3'b000, tick}, 4'd1);

    sw = 4'b0000;
    repeat (10) step();
    chk("man_to_idle", mode, 4'b0000);
    chk("idle_idx_kept", {2'b00, mode_idx}, 4'd1);

    // Bouncing switch never settles for 4 clocks.
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      repeat (2) begin
        step();
        chk("bounce_mode", mode, 4'b0000);
      end
    end
    sw = 4'b0100;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("settle_gap", mode, 4'b0000);
    end
    step();
    chk("settle_mode", mode, 4'b0100);
    chk("settle_idx", {2'b00, mode_idx}, 4'd2);

    // Release switches with auto on: resumes at the last index.
    sw = 4'b0000; auto_en = 1'b1;
    repeat (20) step();
    chk("auto_resume", mode, 4'b0100);
    chk("auto_resume_o", {3'b000, auto}, 4'd1);

    // Asynchronous reset in the middle of AUTO_RUN.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mode", mode, 4'b0000);
    chk("arst_idx", {2'b00, mode_idx}, 4'd0);
    chk("arst_tick", {3'b000, tick}, 4'd0);
    chk("arst_auto", {3'b000, auto}, 4'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rel_clear1", mode, 4'b0000);
    chk("rel_auto", {3'b000, auto}, 4'd1);
    step();
    chk("rel_clear2", mode, 4'b0000);
    step();
    chk("rel_mode", mode, 4'b0001);
    chk("rel_idx", {2'b00, mode_idx}, 4'd0);
    repeat (2) step();
    chk("auto_tick_lo", {3'b000, tick}, 4'd0);
    step();
    chk("auto_tick_hi", {3'b000, tick}, 4'd1);
    step();
    chk("auto_tick_lo2", {3'b000, tick}, 4'd0);

    // Two pattern passes advance the mode.
    pat_done = 1'b1; step(); pat_done = 1'b0;
    chk("one_pass_hold", mode, 4'b0001);
    step();
    pat_done = 1'b1; step(); pat_done = 1'b0;
    chk("adv_gap", mode, 4'b0000);
    chk("adv_idx", {2'b00, mode_idx}, 4'd1);
    chk("adv_auto", {3'b000, auto}, 4'd1);
    step();
    chk("adv_gap2", mode, 4'b0000);
    step();
    chk("adv_mode", mode, 4'b0010);

    for (int k = 2; k <= 4; k++) begin
      ei = 2'(k % 4);
      pat_done = 1'b1; step(); pat_done = 1'b0; step();
      pat_done = 1'b1; step(); pat_done = 1'b0;
      chk("rot_gap", mode, 4'b0000);
      chk("rot_idx", {2'b00, mode_idx}, {2'b00, ei});
      repeat (2) step();
      chk("rot_mode", mode, 4'b0001 << ei);
    end

    // Dwell limit: 64 ticks = 256 clocks.
    repeat (255) step();
    chk("dwell_hold", mode, 4'b0001);
    step();
    chk("dwell_adv", mode, 4'b0000);
    chk("dwell_idx", {2'b00, mode_idx}, 4'd1);
    repeat (2) step();
    chk("dwell_next", mode, 4'b0010);

    // Second pass lands on the 64th tick: only one step.
    pat_done = 1'b1; step(); pat_done = 1'b0;
    repeat (254) step();
    chk("both_hold", mode, 4'b0010);
    pat_done = 1'b1; step(); pat_done = 1'b0;
    chk("both_gap", mode, 4'b0000);
    chk("both_idx", {2'b00, mode_idx}, 4'd2);
    repeat (2) step();
    chk("both_mode", mode, 4'b0100);
    chk("both_idx2", {2'b00, mode_idx}, 4'd2);

    // Manual switch arrives on an advance cycle and wins.
    sw = 4'b1000;
    step();
    pat_done = 1'b1; step(); pat_done = 1'b0;
    repeat (4) step();
    chk("pri_hold", mode, 4'b0100);
    pat_done = 1'b1; step(); pat_done = 1'b0;
    chk("pri_gap", mode, 4'b0000);
    chk("pri_auto", {3'b000, auto}, 4'd0);
    chk("pri_idx", {2'b00, mode_idx}, 4'd3);
    repeat (2) step();
    chk("pri_mode", mode, 4'b1000);
    chk("pri_auto2", {3'b000, auto}, 4'd0);
    chk("pri_idx2", {2'b00, mode_idx}, 4'd3);

    // Multi-hot switches drop to IDLE.
    sw = 4'b1100;
    repeat (6) step();
    chk("multi_hold", mode, 4'b1000);
    step();
    chk("multi_idle", mode, 4'b0000);
    chk("multi_auto", {3'b000, auto}, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
